// File: rtl/pow_dispatch.sv
// Request FIFO and issue/capture sequencer in front of the 16-bit power unit.
// Optional POW_DISPATCH_STATS_EN adds done_cnt and fifo_level outputs.
module pow_dispatch #(
    parameter int DEPTH = 4,
    parameter int XW    = 16,
    parameter int NW    = 8
) (
    input  logic                    clk,
    input  logic                    nrst,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic [XW-1:0]           req_x,
    input  logic [NW-1:0]           req_n,
    output logic                    res_valid,
    input  logic                    res_ack,
    output logic [XW-1:0]           res_data,
`ifdef POW_DISPATCH_STATS_EN
    output logic [15:0]             done_cnt,
    output logic [$clog2(DEPTH):0]  fifo_level,
`endif
    output logic                    pw_start,
    output logic [XW-1:0]           pw_x,
    output logic [NW-1:0]           pw_n,
    input  logic                    pw_ready,
    input  logic [XW-1:0]           pw_out
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = 1;

    localparam logic [1:0] S_IDLE      = 2'd0;
    localparam logic [1:0] S_WAIT_BUSY = 2'd1;
    localparam logic [1:0] S_WAIT_DONE = 2'd2;

    logic [XW-1:0] x_mem_q [DEPTH];
    logic [NW-1:0] n_mem_q [DEPTH];
    logic [AW:0]   wr_ptr_q;
    logic [AW:0]   rd_ptr_q;
    logic [1:0]    state_q;
    logic [1:0]    state_d;
    logic          res_valid_q;
    logic [XW-1:0] res_data_q;
    logic          pw_start_q;
    logic [XW-1:0] pw_x_q;
    logic [NW-1:0] pw_n_q;

    logic full;
    logic empty;
    logic push;
    logic issue;
    logic capture;

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty = (wr_ptr_q == rd_ptr_q);

    assign push    = req_valid && !full;
    assign issue   = (state_q == S_IDLE) && !empty && pw_ready && !res_valid_q;
    assign capture = (state_q == S_WAIT_DONE) && pw_ready;

    assign req_ready = !full;
    assign res_valid = res_valid_q;
    assign res_data  = res_data_q;
    assign pw_start  = pw_start_q;
    assign pw_x      = pw_x_q;
    assign pw_n      = pw_n_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:      if (issue)     state_d = S_WAIT_BUSY;
            S_WAIT_BUSY: if (!pw_ready) state_d = S_WAIT_DONE;
            S_WAIT_DONE: if (pw_ready)  state_d = S_IDLE;
            default:                    state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            for (int i = 0; i < DEPTH; i++) begin
                x_mem_q[i] <= '0;
                n_mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
        end else if (push) begin
            x_mem_q[wr_ptr_q[AW-1:0]] <= req_x;
            n_mem_q[wr_ptr_q[AW-1:0]] <= req_n;
            wr_ptr_q                  <= wr_ptr_q + PTR_ONE;
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            rd_ptr_q   <= '0;
            state_q    <= S_IDLE;
            pw_start_q <= 1'b0;
            pw_x_q     <= '0;
            pw_n_q     <= '0;
        end else begin
            state_q    <= state_d;
            pw_start_q <= issue;
            if (issue) begin
                pw_x_q   <= x_mem_q[rd_ptr_q[AW-1:0]];
                pw_n_q   <= n_mem_q[rd_ptr_q[AW-1:0]];
                rd_ptr_q <= rd_ptr_q + PTR_ONE;
            end
        end
    end

    // Capture cannot collide with ack: issue is held off while a result is pending.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
        end else if (capture) begin
            res_valid_q <= 1'b1;
            res_data_q  <= pw_out;
        end else if (res_ack) begin
            res_valid_q <= 1'b0;
        end
    end

`ifdef POW_DISPATCH_STATS_EN
    logic [15:0] done_cnt_q;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            done_cnt_q <= '0;
        end else if (capture) begin
            done_cnt_q <= done_cnt_q + 16'd1;
        end
    end

    assign done_cnt   = done_cnt_q;
    assign fifo_level = wr_ptr_q - rd_ptr_q;
`endif

endmodule

// File: tb/tb_pow_dispatch.sv
// Directed bench for pow_dispatch with a behavioural power-unit model.
// Exercises ordering, backpressure, consumer stall and mid-operation reset.
module tb_pow_dispatch;

    logic        clk = 1'b0;
    logic        nrst = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [15:0] req_x = '0;
    logic [7:0]  req_n = '0;
    logic        res_valid;
    logic        res_ack = 1'b0;
    logic [15:0] res_data;
    logic        pw_start;
    logic [15:0] pw_x;
    logic [7:0]  pw_n;
    logic        pw_ready;
    logic [15:0] pw_out;
`ifdef POW_DISPATCH_STATS_EN
    logic [15:0] done_cnt;
    logic [2:0]  fifo_level;
`endif

    int checks = 0;
    int errors = 0;
    int start_cnt = 0;
    int busy_len = 5;
    int busy_cnt;
    logic [15:0] pend;

    pow_dispatch #(.DEPTH(4), .XW(16), .NW(8)) dut (
        .clk       (clk),
        .nrst      (nrst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_x     (req_x),
        .req_n     (req_n),
        .res_valid (res_valid),
        .res_ack   (res_ack),
        .res_data  (res_data),
`ifdef POW_DISPATCH_STATS_EN
        .done_cnt  (done_cnt),
        .fifo_level(fifo_level),
`endif
        .pw_start  (pw_start),
        .pw_x      (pw_x),
        .pw_n      (pw_n),
        .pw_ready  (pw_ready),
        .pw_out    (pw_out)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] golden(input logic [15:0] x,
                                           input logic [7:0] n);
        logic [15:0] r;
        r = 16'd1;
        for (int i = 0; i < int'(n); i++) r = r * x;
        return r;
    endfunction

    // Power unit: busy for busy_len cycles after a start, then presents result.
    always @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            pw_ready <= 1'b1;
            pw_out   <= '0;
            busy_cnt <= 0;
            pend     <= '0;
        end else if (busy_cnt == 0) begin
            if (pw_start) begin
                pw_ready <= 1'b0;
                busy_cnt <= busy_len;
                pend     <= golden(pw_x, pw_n);
            end
        end else begin
            busy_cnt <= busy_cnt - 1;
            if (busy_cnt == 1) begin
                pw_ready <= 1'b1;
                pw_out   <= pend;
            end
        end
    end

    always @(posedge clk) if (pw_start === 1'b1) start_cnt <= start_cnt + 1;

    task automatic push(input logic [15:0] x, input logic [7:0] n);
        req_x = x;
        req_n = n;
        req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic ack_pulse();
        res_ack = 1'b1;
        @(negedge clk);
        res_ack = 1'b0;
    endtask

    task automatic wait_valid(output int w);
        w = 0;
        while (res_valid !== 1'b1 && w < 80) begin
            @(negedge clk);
            w++;
        end
    endtask

    task automatic run_one(input logic [15:0] x, input logic [7:0] n,
                           output logic [15:0] data, output int vcnt,
                           output int starts);
        int s0;
        s0 = start_cnt;
        res_ack = 1'b1;
        data = 'x;
        vcnt = 0;
        push(x, n);
        repeat (30) begin
            @(negedge clk);
            if (res_valid === 1'b1) begin
                vcnt++;
                data = res_data;
            end
        end
        starts = start_cnt - s0;
        res_ack = 1'b0;
    endtask

    task automatic test_reset();
        nrst = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (res_valid !== 1'b0 || pw_start !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctl got valid=%b start=%b want 0 0",
                     res_valid, pw_start);
        end
        checks++;
        if (res_data !== 16'd0 || pw_x !== 16'd0 || pw_n !== 8'd0) begin
            errors++;
            $display("FAIL reset_data got %0d/%0d/%0d want 0/0/0",
                     res_data, pw_x, pw_n);
        end
        nrst = 1'b1;
        #1;
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready got %b want 1", req_ready);
        end
`ifdef POW_DISPATCH_STATS_EN
        checks++;
        if (done_cnt !== 16'd0 || fifo_level !== 3'd0) begin
            errors++;
            $display("FAIL reset_stats got %0d/%0d want 0/0",
                     done_cnt, fifo_level);
        end
`endif
        @(negedge clk);
    endtask

    task automatic test_single();
        int s0, rdy_low, rise, vat, vcnt;
        logic prev;
        logic [15:0] data;
        s0 = start_cnt;
        rdy_low = 0;
        rise = -1;
        vat = -1;
        vcnt = 0;
        data = 'x;
        res_ack = 1'b1;
        push(16'd3, 8'd4);
        @(negedge clk);
        checks++;
        if (pw_start !== 1'b1) begin
            errors++;
            $display("FAIL single_latency got pw_start=%b want 1", pw_start);
        end
        prev = pw_ready;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (req_ready !== 1'b1) rdy_low++;
            if (prev === 1'b0 && pw_ready === 1'b1 && rise < 0) rise = i;
            if (res_valid === 1'b1) begin
                if (vat < 0) vat = i;
                vcnt++;
                data = res_data;
            end
            prev = pw_ready;
        end
        res_ack = 1'b0;
        checks++;
        if (start_cnt - s0 != 1) begin
            errors++;
            $display("FAIL single_starts got %0d want 1", start_cnt - s0);
        end
        checks++;
        if (vcnt != 1) begin
            errors++;
            $display("FAIL single_valid_cycles got %0d want 1", vcnt);
        end
        checks++;
        if (data !== 16'd81) begin
            errors++;
            $display("FAIL single_data got %0d want 81", data);
        end
        checks++;
        if (rdy_low != 0) begin
            errors++;
            $display("FAIL single_ready got %0d low cycles want 0", rdy_low);
        end
        checks++;
        if (rise < 0 || vat != rise + 1) begin
            errors++;
            $display("FAIL single_res_latency got %0d want %0d", vat, rise + 1);
        end
    endtask

    task automatic test_zero_exp();
        logic [15:0] d;
        int v, s;
        run_one(16'd1234, 8'd0, d, v, s);
        checks++;
        if (d !== 16'd1 || v != 1) begin
            errors++;
            $display("FAIL zero_1234 got %0d (valid %0d) want 1 (1)", d, v);
        end
        run_one(16'd0, 8'd0, d, v, s);
        checks++;
        if (d !== 16'd1 || v != 1) begin
            errors++;
            $display("FAIL zero_0 got %0d (valid %0d) want 1 (1)", d, v);
        end
    endtask

    task automatic test_overflow();
        logic [15:0] d;
        int v, s;
        run_one(16'd3, 8'd11, d, v, s);
        checks++;
        if (d !== 16'd46075 || s != 1) begin
            errors++;
            $display("FAIL wrap_3_11 got %0d (starts %0d) want 46075 (1)", d, s);
        end
        run_one(16'd2, 8'd16, d, v, s);
        checks++;
        if (d !== 16'd0 || v != 1) begin
            errors++;
            $display("FAIL wrap_2_16 got %0d (valid %0d) want 0 (1)", d, v);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] xs [5];
        logic [7:0]  ns [5];
        logic [15:0] ex [5];
        int s0, acc, w;
        xs[0] = 2; ns[0] = 1; ex[0] = 2;
        xs[1] = 2; ns[1] = 2; ex[1] = 4;
        xs[2] = 2; ns[2] = 3; ex[2] = 8;
        xs[3] = 2; ns[3] = 4; ex[3] = 16;
        xs[4] = 5; ns[4] = 3; ex[4] = 125;
        res_ack = 1'b0;
        s0 = start_cnt;
        acc = 0;
        for (int i = 0; i < 5; i++) begin
            req_x = xs[i];
            req_n = ns[i];
            req_valid = 1'b1;
            if (req_ready === 1'b1) acc++;
            @(negedge clk);
        end
        req_valid = 1'b0;
        checks++;
        if (acc != 5) begin
            errors++;
            $display("FAIL b2b_accepts got %0d want 5", acc);
        end
        checks++;
        if (req_ready !== 1'b0) begin
            errors++;
            $display("FAIL b2b_full_ready got %b want 0", req_ready);
        end
`ifdef POW_DISPATCH_STATS_EN
        checks++;
        if (fifo_level !== 3'd4) begin
            errors++;
            $display("FAIL b2b_level got %0d want 4", fifo_level);
        end
`endif
        for (int k = 0; k < 5; k++) begin
            wait_valid(w);
            checks++;
            if (res_valid !== 1'b1 || res_data !== ex[k]) begin
                errors++;
                $display("FAIL b2b_result%0d got %0d (valid %b) want %0d",
                         k, res_data, res_valid, ex[k]);
            end
            if (k == 0) begin
                repeat (10) @(negedge clk);
                checks++;
                if (start_cnt - s0 != 1 || res_data !== 16'd2) begin
                    errors++;
                    $display("FAIL b2b_hold got starts=%0d data=%0d want 1 2",
                             start_cnt - s0, res_data);
                end
            end
            ack_pulse();
        end
        checks++;
        if (req_ready !== 1'b1 || start_cnt - s0 != 5) begin
            errors++;
            $display("FAIL b2b_drain got ready=%b starts=%0d want 1 5",
                     req_ready, start_cnt - s0);
        end
    endtask

    task automatic test_stall();
        int s0, w, bad;
        res_ack = 1'b0;
        s0 = start_cnt;
        push(16'd7, 8'd2);
        push(16'd3, 8'd3);
        wait_valid(w);
        checks++;
        if (res_valid !== 1'b1 || res_data !== 16'd49) begin
            errors++;
            $display("FAIL stall_first got %0d want 49", res_data);
        end
        bad = 0;
        repeat (20) begin
            @(negedge clk);
            if (res_valid !== 1'b1 || res_data !== 16'd49) bad++;
        end
        checks++;
        if (bad != 0 || start_cnt - s0 != 1) begin
            errors++;
            $display("FAIL stall_hold got bad=%0d starts=%0d want 0 1",
                     bad, start_cnt - s0);
        end
        ack_pulse();
        checks++;
        if (pw_start !== 1'b0) begin
            errors++;
            $display("FAIL stall_ack_edge got pw_start=%b want 0", pw_start);
        end
        @(negedge clk);
        checks++;
        if (pw_start !== 1'b1) begin
            errors++;
            $display("FAIL stall_reissue got pw_start=%b want 1", pw_start);
        end
        wait_valid(w);
        checks++;
        if (res_valid !== 1'b1 || res_data !== 16'd27) begin
            errors++;
            $display("FAIL stall_second got %0d want 27", res_data);
        end
        ack_pulse();
    endtask

    task automatic test_stats();
`ifdef POW_DISPATCH_STATS_EN
        checks++;
        if (done_cnt !== 16'd12 || fifo_level !== 3'd0) begin
            errors++;
            $display("FAIL stats_count got %0d/%0d want 12/0",
                     done_cnt, fifo_level);
        end
`endif
    endtask

    task automatic test_reset_midop();
        int s1;
        logic [15:0] d;
        int v, s;
        res_ack = 1'b0;
        push(16'd9, 8'd2);
        push(16'd4, 8'd2);
        push(16'd6, 8'd2);
        @(negedge clk);
        checks++;
        if (pw_ready !== 1'b0 || pw_x !== 16'd9) begin
            errors++;
            $display("FAIL midop_busy got ready=%b x=%0d want 0 9",
                     pw_ready, pw_x);
        end
`ifdef POW_DISPATCH_STATS_EN
        checks++;
        if (fifo_level !== 3'd2) begin
            errors++;
            $display("FAIL midop_level got %0d want 2", fifo_level);
        end
`endif
        nrst = 1'b0;
        #1;
        checks++;
        if (res_valid !== 1'b0 || pw_start !== 1'b0 || req_ready !== 1'b1) begin
            errors++;
            $display("FAIL midop_reset got valid=%b start=%b ready=%b want 0 0 1",
                     res_valid, pw_start, req_ready);
        end
        checks++;
        if (pw_x !== 16'd0 || pw_n !== 8'd0) begin
            errors++;
            $display("FAIL midop_pw got %0d/%0d want 0/0", pw_x, pw_n);
        end
`ifdef POW_DISPATCH_STATS_EN
        checks++;
        if (done_cnt !== 16'd0 || fifo_level !== 3'd0) begin
            errors++;
            $display("FAIL midop_stats got %0d/%0d want 0/0",
                     done_cnt, fifo_level);
        end
`endif
        @(negedge clk);
        nrst = 1'b1;
        s1 = start_cnt;
        repeat (10) @(negedge clk);
        checks++;
        if (start_cnt != s1 || res_valid !== 1'b0) begin
            errors++;
            $display("FAIL midop_idle got starts=%0d valid=%b want 0 0",
                     start_cnt - s1, res_valid);
        end
        run_one(16'd3, 8'd2, d, v, s);
        checks++;
        if (d !== 16'd9 || s != 1) begin
            errors++;
            $display("FAIL midop_after got %0d (starts %0d) want 9 (1)", d, s);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_zero_exp();
        test_overflow();
        test_back_to_back();
        test_stall();
        test_stats();
        test_reset_midop();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
